// File: rtl/bp_table_sched.sv
// BTB owner: combinational fetch lookup, queued execute updates, clear sweep.
// Optional statistics counters are built when BP_STATS_EN is defined.
module bp_table_sched #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int UQ_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_jump,
    input  logic        flush_req,
    output logic        clear_busy,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_allocs
);
    localparam int N  = 1 << INDEX_BITS;
    localparam int PW = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int CW = $clog2(UQ_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_jump;
    } upd_t;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   clr_idx;
    upd_t                    fifo [UQ_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic                    t_valid [N];
    logic [1:0]              t_ctr   [N];
    logic [TAG_BITS-1:0]     t_tag   [N];
    logic [31:0]             t_tgt   [N];

    logic [INDEX_BITS-1:0]   l_idx;
    logic [TAG_BITS-1:0]     l_tag;
    upd_t                    head;
    logic [INDEX_BITS-1:0]   h_idx;
    logic [TAG_BITS-1:0]     h_tag;
    logic                    h_hit;
    logic                    h_alloc;
    logic                    h_write;
    logic [1:0]              h_ctr;
    logic [31:0]             h_tgt;
    logic                    do_enq;
    logic                    do_deq;
    logic                    unused_ok;

    assign l_idx = lookup_pc[2 +: INDEX_BITS];
    assign l_tag = lookup_pc[2+INDEX_BITS +: TAG_BITS];

    assign lookup_hit    = (state == RUN) && t_valid[l_idx]
                           && (t_tag[l_idx] == l_tag);
    assign lookup_taken  = lookup_hit & t_ctr[l_idx][1];
    assign lookup_target = lookup_hit ? t_tgt[l_idx] : '0;

    assign clear_busy = (state == CLEAR);
    assign upd_ready  = (state == RUN) && (count != CW'(UQ_DEPTH));

    assign head    = fifo[rd_ptr];
    assign h_idx   = head.pc[2 +: INDEX_BITS];
    assign h_tag   = head.pc[2+INDEX_BITS +: TAG_BITS];
    assign h_hit   = t_valid[h_idx] && (t_tag[h_idx] == h_tag);
    assign h_alloc = !h_hit && (head.taken || head.is_jump);
    assign do_deq  = (state == RUN) && !flush_req && (count != '0);
    assign do_enq  = upd_valid && upd_ready && !flush_req;
    assign h_write = do_deq && (h_hit || h_alloc);

    assign unused_ok = ^{lookup_pc, head.pc};

    // New counter/target for the entry the FIFO head resolves to.
    always_comb begin
        h_ctr = t_ctr[h_idx];
        h_tgt = t_tgt[h_idx];
        if (!h_hit) begin
            h_ctr = head.is_jump ? 2'b11 : 2'b10;
            h_tgt = head.target;
        end else begin
            if (head.taken) h_tgt = head.target;
            unique case (1'b1)
                head.is_jump:
                    h_ctr = 2'b11;
                !head.is_jump && head.taken:
                    h_ctr = (t_ctr[h_idx] == 2'b00) ? 2'b01 : 2'b11;
                !head.is_jump && !head.taken:
                    h_ctr = (t_ctr[h_idx] == 2'b11) ? 2'b10 : 2'b00;
            endcase
        end
    end

    // Single table write port: sweep writes in CLEAR, head RMW in RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            t_valid[clr_idx] <= 1'b0;
            t_ctr[clr_idx]   <= 2'b01;
            t_tag[clr_idx]   <= '0;
            t_tgt[clr_idx]   <= '0;
        end else if (h_write) begin
            t_valid[h_idx] <= 1'b1;
            t_ctr[h_idx]   <= h_ctr;
            t_tag[h_idx]   <= h_tag;
            t_tgt[h_idx]   <= h_tgt;
        end
    end

    // FIFO storage; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            fifo[wr_ptr] <= '{pc: upd_pc, target: upd_target,
                              taken: upd_taken, is_jump: upd_is_jump};
        end
    end

    // Sequencer: clear sweep, flush restart, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= CLEAR;
            clr_idx <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (flush_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == {INDEX_BITS{1'b1}}) state <= RUN;
        end else begin
            if (do_enq) begin
                wr_ptr <= (wr_ptr == PW'(UQ_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= (rd_ptr == PW'(UQ_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_enq) - CW'(do_deq);
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] n_upd;
    logic [31:0] n_alloc;

    // Wrapping statistics, cleared only by reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            n_upd   <= '0;
            n_alloc <= '0;
        end else begin
            if (do_deq) n_upd <= n_upd + 1'b1;
            if (do_deq && h_alloc) n_alloc <= n_alloc + 1'b1;
        end
    end

    assign stat_updates = n_upd;
    assign stat_allocs  = n_alloc;
`else
    assign stat_updates = '0;
    assign stat_allocs  = '0;
`endif

endmodule
